// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack imem port and feeds IF/ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module pipe_if_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] Instruction_o,
    output logic [15:0] PCadder1_sum_o,
    output logic        instr_valid_o,
    output logic [15:0] fetch_cnt_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_PEND, S_DROP} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] pcp2_reg, pcp2_next;
    logic        valid_reg, valid_next;
    logic [15:0] pend_instr_reg, pend_instr_next;
    logic [15:0] pend_pcp2_reg, pend_pcp2_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [15:0] drop_addr_reg, drop_addr_next;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_reg + 16'd2;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            instr_reg      <= NOP_INSTR;
            pcp2_reg       <= 16'h0000;
            valid_reg      <= 1'b0;
            pend_instr_reg <= NOP_INSTR;
            pend_pcp2_reg  <= 16'h0000;
            pend_valid_reg <= 1'b0;
            drop_addr_reg  <= RESET_PC;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
            pcp2_reg       <= pcp2_next;
            valid_reg      <= valid_next;
            pend_instr_reg <= pend_instr_next;
            pend_pcp2_reg  <= pend_pcp2_next;
            pend_valid_reg <= pend_valid_next;
            drop_addr_reg  <= drop_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        instr_next      = instr_reg;
        pcp2_next       = pcp2_reg;
        valid_next      = valid_reg;
        pend_instr_next = pend_instr_reg;
        pend_pcp2_next  = pend_pcp2_reg;
        pend_valid_next = pend_valid_reg;
        drop_addr_next  = drop_addr_reg;

        // IF/ID takes the buffer on every unstalled edge
        if (valid_reg && !stall_i) begin
            valid_next = 1'b0;
        end

        if (branch_taken_i) begin
            pc_next         = {branch_target_i[15:1], 1'b0};
            valid_next      = 1'b0;
            pend_valid_next = 1'b0;
            case (state_reg)
                S_REQ: begin
                    if (imem_ack_i) begin
                        state_next = S_REQ;
                    end else begin
                        // request in flight: keep driving its address until it acks
                        state_next     = S_DROP;
                        drop_addr_next = pc_reg;
                    end
                end
                S_DROP:  state_next = S_DROP;
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state_reg)
                S_IDLE: state_next = S_REQ;
                S_REQ: begin
                    if (imem_ack_i) begin
                        pc_next = pc_plus2;
                        if (!valid_reg || !stall_i) begin
                            instr_next = imem_rdata_i;
                            pcp2_next  = pc_plus2;
                            valid_next = 1'b1;
                        end else begin
                            pend_instr_next = imem_rdata_i;
                            pend_pcp2_next  = pc_plus2;
                            pend_valid_next = 1'b1;
                            state_next      = S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (!stall_i) begin
                        instr_next      = pend_instr_reg;
                        pcp2_next       = pend_pcp2_reg;
                        valid_next      = pend_valid_reg;
                        pend_valid_next = 1'b0;
                        state_next      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign imem_req_o     = (state_reg == S_REQ) || (state_reg == S_DROP);
    assign imem_addr_o    = (state_reg == S_DROP) ? drop_addr_reg : pc_reg;
    assign Instruction_o  = valid_reg ? instr_reg : NOP_INSTR;
    assign PCadder1_sum_o = pcp2_reg;
    assign instr_valid_o  = valid_reg;

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt_reg;
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_reg <= 16'h0000;
            stall_cnt_reg <= 16'h0000;
        end else begin
            if (valid_reg && !stall_i && (fetch_cnt_reg != 16'hFFFF)) begin
                fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
            end
            if (valid_reg && stall_i && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;
    assign stall_cnt_o = stall_cnt_reg;
`else
    assign fetch_cnt_o = 16'h0000;
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Directed bench for pipe_if_fetch: hand-computed expectations checked with immediate assertions.
`timescale 1ns/1ps
module tb_pipe_if_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        branch_taken_i;
    logic [15:0] branch_target_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_rdata_i;
    logic [15:0] Instruction_o;
    logic [15:0] PCadder1_sum_o;
    logic        instr_valid_o;
    logic [15:0] fetch_cnt_o;
    logic [15:0] stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_if_fetch #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .Instruction_o   (Instruction_o),
        .PCadder1_sum_o  (PCadder1_sum_o),
        .instr_valid_o   (instr_valid_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Counter ports read zero unless the perf counters are compiled in
    function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef IF_PERF_CNT_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic chk_buf(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] p2);
        chk({tag, "_valid"}, {15'b0, instr_valid_o}, {15'b0, v});
        chk({tag, "_instr"}, Instruction_o, ins);
        chk({tag, "_pcp2"}, PCadder1_sum_o, p2);
    endtask

    task automatic chk_port(input string tag, input logic rq, input logic [15:0] ad);
        chk({tag, "_req"}, {15'b0, imem_req_o}, {15'b0, rq});
        chk({tag, "_addr"}, imem_addr_o, ad);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 16'h0000;
        imem_ack_i = 1'b0; imem_rdata_i = 16'h0000;
        tick(); tick();
        chk_port("rst", 1'b0, 16'h0000);
        chk_buf("rst", 1'b0, 16'h0000, 16'h0000);
        chk("rst_fcnt", fetch_cnt_o, 16'h0000);
        chk("rst_scnt", stall_cnt_o, 16'h0000);
        $display("reset: req=%b addr=%h valid=%b", imem_req_o, imem_addr_o, instr_valid_o);

        rst_n = 1'b1;
        chk_port("idle", 1'b0, 16'h0000);
        tick();
        chk_port("req0", 1'b1, 16'h0000);

        // zero-wait memory, back-to-back fetches
        imem_ack_i = 1'b1; imem_rdata_i = 16'h1111;
        tick();
        chk_buf("zw1", 1'b1, 16'h1111, 16'h0002);
        chk_port("zw1", 1'b1, 16'h0002);
        $display("zw fetch 1: instr=%h pcp2=%h", Instruction_o, PCadder1_sum_o);
        imem_rdata_i = 16'h2222;
        tick();
        chk_buf("zw2", 1'b1, 16'h2222, 16'h0004);
        chk_port("zw2", 1'b1, 16'h0004);
        $display("zw fetch 2: instr=%h pcp2=%h", Instruction_o, PCadder1_sum_o);
        imem_ack_i = 1'b0;
        tick();
        chk_buf("zw_drain", 1'b0, 16'h0000, 16'h0004);
        chk("zw_fcnt", fetch_cnt_o, cnt_exp(16'd2));

        // ack delayed by three cycles
        for (int i = 0; i < 3; i++) begin
            chk_port("wait", 1'b1, 16'h0004);
            chk("wait_valid", {15'b0, instr_valid_o}, 16'h0000);
            tick();
        end
        imem_ack_i = 1'b1; imem_rdata_i = 16'h3333;
        chk_port("wait_ack", 1'b1, 16'h0004);
        tick();
        imem_ack_i = 1'b0;
        chk_buf("wait_done", 1'b1, 16'h3333, 16'h0006);
        chk_port("wait_done", 1'b1, 16'h0006);
        $display("delayed fetch: instr=%h pcp2=%h", Instruction_o, PCadder1_sum_o);

        // stall with a full buffer while a second ack lands
        stall_i = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 16'h4444;
        tick();
        imem_ack_i = 1'b0; imem_rdata_i = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            chk_port("pend", 1'b0, 16'h0008);
            chk_buf("pend", 1'b1, 16'h3333, 16'h0006);
            tick();
        end
        chk_buf("pend_last", 1'b1, 16'h3333, 16'h0006);
        chk("pend_scnt", stall_cnt_o, cnt_exp(16'd4));
        stall_i = 1'b0;
        tick();
        chk_buf("unstall", 1'b1, 16'h4444, 16'h0008);
        chk_port("unstall", 1'b1, 16'h0008);
        $display("after stall: instr=%h pcp2=%h", Instruction_o, PCadder1_sum_o);

        // redirect while request outstanding and buffer valid
        branch_taken_i = 1'b1; branch_target_i = 16'h0041;
        tick();
        branch_taken_i = 1'b0;
        chk_buf("redir", 1'b0, 16'h0000, 16'h0008);
        chk_port("redir_old", 1'b1, 16'h0008);
        imem_ack_i = 1'b1; imem_rdata_i = 16'hDEAD;
        tick();
        imem_ack_i = 1'b0;
        chk("drop_valid", {15'b0, instr_valid_o}, 16'h0000);
        chk_port("redir_new", 1'b1, 16'h0040);
        imem_ack_i = 1'b1; imem_rdata_i = 16'h5555;
        tick();
        imem_ack_i = 1'b0;
        chk_buf("redir_fetch", 1'b1, 16'h5555, 16'h0042);
        chk_port("redir_fetch", 1'b1, 16'h0042);
        chk("redir_fcnt", fetch_cnt_o, cnt_exp(16'd4));
        chk("redir_scnt", stall_cnt_o, cnt_exp(16'd4));
        $display("redirect fetch: instr=%h pcp2=%h", Instruction_o, PCadder1_sum_o);

        // redirect with same-cycle ack, then wrap at FFFE
        branch_taken_i = 1'b1; branch_target_i = 16'hFFFF;
        imem_ack_i = 1'b1; imem_rdata_i = 16'hBEEF;
        tick();
        branch_taken_i = 1'b0;
        chk("wrap_redir_valid", {15'b0, instr_valid_o}, 16'h0000);
        chk_port("wrap_redir", 1'b1, 16'hFFFE);
        imem_rdata_i = 16'h7777;
        tick();
        chk_buf("wrap", 1'b1, 16'h7777, 16'h0000);
        chk_port("wrap", 1'b1, 16'h0000);
        $display("wrap fetch: instr=%h pcp2=%h", Instruction_o, PCadder1_sum_o);
        imem_rdata_i = 16'h8888;
        tick();
        imem_ack_i = 1'b0;
        chk_buf("pre_rst", 1'b1, 16'h8888, 16'h0002);
        chk("pre_rst_fcnt", fetch_cnt_o, cnt_exp(16'd6));

        // asynchronous reset mid-request, then a stray ack
        rst_n = 1'b0;
        #1;
        chk_port("arst", 1'b0, 16'h0000);
        chk_buf("arst", 1'b0, 16'h0000, 16'h0000);
        chk("arst_fcnt", fetch_cnt_o, 16'h0000);
        chk("arst_scnt", stall_cnt_o, 16'h0000);
        imem_ack_i = 1'b1; imem_rdata_i = 16'h9999;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        chk_buf("stray", 1'b0, 16'h0000, 16'h0000);
        chk_port("stray", 1'b1, 16'h0000);
        chk("stray_fcnt", fetch_cnt_o, 16'h0000);
        $display("after stray ack: req=%b addr=%h valid=%b", imem_req_o, imem_addr_o, instr_valid_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
